// File: rtl/wb_burst_master.sv
// Wishbone B3 burst initiator: turns one command descriptor into a classic or
// incrementing-burst (linear/wrap4/wrap8/wrap16) read or write cycle.
module wb_burst_master #(
  parameter int MAX_LEN_W = 4
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [31:0]          cmd_adr_i,
  input  logic [MAX_LEN_W-1:0] cmd_len_i,
  input  logic [1:0]           cmd_bte_i,
  input  logic [31:0]          wdat_i,
  input  logic [3:0]           wsel_i,
  input  logic                 wdat_valid_i,
  output logic                 wdat_ready_o,
  output logic [31:0]          rdat_o,
  output logic                 rdat_valid_o,
  output logic                 done_o,
  output logic [31:0]          wb_adr_o,
  output logic [31:0]          wb_dat_o,
  output logic [3:0]           wb_sel_o,
  output logic                 wb_we_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic [2:0]           wb_cti_o,
  output logic [1:0]           wb_bte_o,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t               state;
  logic [MAX_LEN_W-1:0] beats_left;
  logic                 rst_sync_p0, rst_sync_p1;
  logic                 ack_beat;

  // Wrapping bursts only advance the low address bits inside their aligned block.
  function automatic logic [31:0] next_adr(input logic [31:0] adr, input logic [1:0] bte);
    case (bte)
      2'b01:   return {adr[31:4], adr[3:0] + 4'd4};
      2'b10:   return {adr[31:5], adr[4:0] + 5'd4};
      2'b11:   return {adr[31:6], adr[5:0] + 6'd4};
      default: return adr + 32'd4;
    endcase
  endfunction

  // Reset asserts asynchronously but is released on a clock edge.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rst_sync_p0 <= 1'b0;
      rst_sync_p1 <= 1'b0;
    end else begin
      rst_sync_p0 <= 1'b1;
      rst_sync_p1 <= rst_sync_p0;
    end
  end

  assign cmd_ready_o  = (state == IDLE);
  assign wb_stb_o     = (state == READ) || ((state == WRITE) && wdat_valid_i);
  assign wb_sel_o     = (state == READ) ? 4'hf : ((state == WRITE) ? wsel_i : 4'h0);
  assign wb_dat_o     = wdat_i;
  assign ack_beat     = wb_ack_i && wb_stb_o;
  assign wdat_ready_o = ack_beat && wb_we_o;

  always_ff @(posedge wb_clk or negedge rst_sync_p1) begin
    if (!rst_sync_p1) begin
      state        <= IDLE;
      beats_left   <= '0;
      wb_cyc_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_cti_o     <= 3'b000;
      wb_bte_o     <= 2'b00;
      rdat_o       <= '0;
      rdat_valid_o <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      rdat_valid_o <= 1'b0;
      done_o       <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            state      <= cmd_we_i ? WRITE : READ;
            wb_cyc_o   <= 1'b1;
            wb_we_o    <= cmd_we_i;
            wb_adr_o   <= {cmd_adr_i[31:2], 2'b00};
            wb_bte_o   <= cmd_bte_i;
            wb_cti_o   <= (cmd_len_i == '0) ? 3'b000 : 3'b010;
            beats_left <= cmd_len_i;
          end
        end
        READ, WRITE: begin
          if (ack_beat) begin
            if (state == READ) begin
              rdat_o       <= wb_dat_i;
              rdat_valid_o <= 1'b1;
            end
            if (beats_left == '0) begin
              state    <= IDLE;
              wb_cyc_o <= 1'b0;
              wb_we_o  <= 1'b0;
              done_o   <= 1'b1;
            end else begin
              wb_adr_o   <= next_adr(wb_adr_o, wb_bte_o);
              beats_left <= beats_left - 1'b1;
              wb_cti_o   <= (beats_left == MAX_LEN_W'(1)) ? 3'b111 : 3'b010;
            end
          end
        end
        default: begin
          state    <= IDLE;
          wb_cyc_o <= 1'b0;
          wb_we_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: drives the Wishbone slave side by hand
// and checks each bus cycle against hand-computed values.
module tb_wb_burst_master;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [3:0]  cmd_len_i;
  logic [1:0]  cmd_bte_i;
  logic [31:0] wdat_i;
  logic [3:0]  wsel_i;
  logic        wdat_valid_i, wdat_ready_o;
  logic [31:0] rdat_o;
  logic        rdat_valid_o, done_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  int vectors = 0;
  int miscompares = 0;
  int rdy_cnt = 0;
  logic [31:0] w4_adr [4] = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
  logic [31:0] wr_adr [8] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4,
                              32'h8, 32'hC, 32'h10, 32'h14};
  logic [31:0] exp_adr;

  always #5 wb_clk = ~wb_clk;

  wb_burst_master #(.MAX_LEN_W(4)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i), .cmd_bte_i(cmd_bte_i),
    .wdat_i(wdat_i), .wsel_i(wsel_i), .wdat_valid_i(wdat_valid_i),
    .wdat_ready_o(wdat_ready_o), .rdat_o(rdat_o), .rdat_valid_o(rdat_valid_o),
    .done_o(done_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    wb_rst_n = 1'b1;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_len_i = '0; cmd_bte_i = '0;
    wdat_i = 32'h12345678; wsel_i = 4'h0; wdat_valid_i = 1'b0;
    wb_dat_i = '0; wb_ack_i = 1'b0;
    step(); step(); step();

    // Reset values
    wb_rst_n = 1'b0;
    #1;
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_dat", wb_dat_o, 32'h12345678);
    chk("rst_sel", wb_sel_o, 0);
    chk("rst_cti", wb_cti_o, 0);
    chk("rst_bte", wb_bte_o, 0);
    chk("rst_rdat", rdat_o, 0);
    chk("rst_rvld", rdat_valid_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ready", cmd_ready_o, 1);
    step(); step();
    wb_rst_n = 1'b1;
    step(); step(); step();
    chk("post_rst_ready", cmd_ready_o, 1);

    // Single classic read, low address bits dropped
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 32'h103; cmd_len_i = 4'd0; cmd_bte_i = 2'b00;
    step();
    cmd_valid_i = 1'b0;
    chk("s_cyc", wb_cyc_o, 1);
    chk("s_stb", wb_stb_o, 1);
    chk("s_adr", wb_adr_o, 32'h100);
    chk("s_cti", wb_cti_o, 3'b000);
    chk("s_sel", wb_sel_o, 4'hf);
    chk("s_we", wb_we_o, 0);
    chk("s_ready", cmd_ready_o, 0);
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEADBEEF;
    step();
    wb_ack_i = 1'b0;
    chk("s_rvld", rdat_valid_o, 1);
    chk("s_rdat", rdat_o, 32'hDEADBEEF);
    chk("s_done", done_o, 1);
    chk("s_cyc_end", wb_cyc_o, 0);
    step();
    chk("s_done_end", done_o, 0);
    chk("s_rvld_end", rdat_valid_o, 0);
    chk("s_ready_end", cmd_ready_o, 1);

    // Wrap4 read
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 32'h1008; cmd_len_i = 4'd3; cmd_bte_i = 2'b01;
    step();
    cmd_valid_i = 1'b0;
    chk("w4_bte", wb_bte_o, 2'b01);
    for (int i = 0; i < 4; i++) begin
      chk("w4_adr", wb_adr_o, w4_adr[i]);
      chk("w4_cti", wb_cti_o, (i == 3) ? 3'b111 : 3'b010);
      wb_ack_i = 1'b1; wb_dat_i = 32'hA0 + i;
      step();
      chk("w4_rvld", rdat_valid_o, 1);
      chk("w4_rdat", rdat_o, 32'hA0 + i);
    end
    wb_ack_i = 1'b0;
    chk("w4_done", done_o, 1);
    chk("w4_cyc_end", wb_cyc_o, 0);
    step();
    chk("w4_done_end", done_o, 0);

    // Linear write across 2^32 with a two-cycle data stall and a stray ack
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 32'hFFFFFFF8; cmd_len_i = 4'd7; cmd_bte_i = 2'b00;
    step();
    cmd_valid_i = 1'b0;
    chk("wr_cyc", wb_cyc_o, 1);
    chk("wr_we", wb_we_o, 1);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        wdat_valid_i = 1'b0; wb_ack_i = 1'b1;
        #1;
        chk("wr_stall_stb", wb_stb_o, 0);
        chk("wr_stall_rdy", wdat_ready_o, 0);
        chk("wr_stall_adr", wb_adr_o, 32'h4);
        chk("wr_stall_cti", wb_cti_o, 3'b010);
        step();
        wb_ack_i = 1'b0;
        #1;
        chk("wr_stall2_adr", wb_adr_o, 32'h4);
        chk("wr_stall2_stb", wb_stb_o, 0);
        chk("wr_stall2_cyc", wb_cyc_o, 1);
        step();
      end
      wdat_valid_i = 1'b1; wdat_i = 32'hC0DE0000 + i; wsel_i = (i % 2 == 1) ? 4'h3 : 4'hc;
      wb_ack_i = 1'b1;
      #1;
      chk("wr_adr", wb_adr_o, wr_adr[i]);
      chk("wr_cti", wb_cti_o, (i == 7) ? 3'b111 : 3'b010);
      chk("wr_stb", wb_stb_o, 1);
      chk("wr_sel", wb_sel_o, (i % 2 == 1) ? 4'h3 : 4'hc);
      chk("wr_dat", wb_dat_o, 32'hC0DE0000 + i);
      if (wdat_ready_o) rdy_cnt++;
      step();
    end
    wb_ack_i = 1'b0; wdat_valid_i = 1'b0;
    #1;
    chk("wr_done", done_o, 1);
    chk("wr_cyc_end", wb_cyc_o, 0);
    chk("wr_we_end", wb_we_o, 0);
    chk("wr_rdy_cnt", rdy_cnt, 8);
    step();
    chk("wr_done_end", done_o, 0);

    // Wrap16 read with the slave acking every third cycle; busy command ignored
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 32'h2034; cmd_len_i = 4'd15; cmd_bte_i = 2'b11;
    step();
    cmd_we_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_adr = 32'h2000 | ((32'h34 + 32'(4 * i)) & 32'h3C);
      wb_ack_i = 1'b0;
      step(); step();
      if (i == 0) begin
        chk("w16_busy_ready", cmd_ready_o, 0);
        chk("w16_busy_we", wb_we_o, 0);
        cmd_valid_i = 1'b0;
      end
      chk("w16_nodone", done_o, 0);
      chk("w16_adr", wb_adr_o, exp_adr);
      chk("w16_cti", wb_cti_o, (i == 15) ? 3'b111 : 3'b010);
      wb_ack_i = 1'b1; wb_dat_i = 32'h5000 + i;
      step();
      chk("w16_rvld", rdat_valid_o, 1);
      chk("w16_rdat", rdat_o, 32'h5000 + i);
    end
    wb_ack_i = 1'b0;
    chk("w16_done", done_o, 1);
    chk("w16_cyc_end", wb_cyc_o, 0);
    step();
    chk("w16_done_end", done_o, 0);

    // Reset pulled at beat 2 of an 8-beat read
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 32'h3000; cmd_len_i = 4'd7; cmd_bte_i = 2'b00;
    step();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wb_ack_i = 1'b1; wb_dat_i = 32'h6000 + i;
      step();
    end
    wb_ack_i = 1'b0;
    #1;
    chk("ra_adr", wb_adr_o, 32'h3008);
    chk("ra_cyc", wb_cyc_o, 1);
    #2;
    wb_rst_n = 1'b0;
    #1;
    chk("ra_cyc_async", wb_cyc_o, 0);
    chk("ra_stb_async", wb_stb_o, 0);
    step();
    chk("ra_nodone0", done_o, 0);
    step();
    chk("ra_nodone1", done_o, 0);
    wb_rst_n = 1'b1;
    step(); step(); step();
    chk("ra_ready", cmd_ready_o, 1);
    chk("ra_cyc_idle", wb_cyc_o, 0);
    chk("ra_nodone2", done_o, 0);

    // Fresh two-beat write after the abandoned burst
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 32'h43; cmd_len_i = 4'd1; cmd_bte_i = 2'b00;
    wdat_valid_i = 1'b1; wsel_i = 4'hf; wdat_i = 32'hAA;
    step();
    cmd_valid_i = 1'b0;
    wb_ack_i = 1'b1;
    #1;
    chk("nw_adr0", wb_adr_o, 32'h40);
    chk("nw_cti0", wb_cti_o, 3'b010);
    chk("nw_rdy0", wdat_ready_o, 1);
    step();
    chk("nw_adr1", wb_adr_o, 32'h44);
    chk("nw_cti1", wb_cti_o, 3'b111);
    step();
    wb_ack_i = 1'b0; wdat_valid_i = 1'b0;
    chk("nw_done", done_o, 1);
    chk("nw_cyc_end", wb_cyc_o, 0);
    step();
    chk("nw_done_end", done_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Wishbone B3 initiator that turns single command descriptors into classic or incrementing-burst read/write cycles on a 32-bit Wishbone bus. It is the counterpart of the SDRAM controller's Wishbone ports: DMA engines and test logic drive SDRAM through it using bursts the ports' buffers accept (CTI 010 with BTE linear/wrap4/wrap8/wrap16). It runs in a single clock domain.

## Interface
- MAX_LEN_W, 4: width of cmd_len; a burst is cmd_len+1 beats (1..16).
- wb_clk  in  1  clock; all logic on rising edge.
- wb_rst_n  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  high in IDLE; command accepted on cmd_valid_i & cmd_ready_o.
- cmd_we_i  in  1  1 = write burst, 0 = read burst.
- cmd_adr_i  in  32  start byte address; bits [1:0] ignored and forced to 0.
- cmd_len_i  in  MAX_LEN_W  beats minus one.
- cmd_bte_i  in  2  00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wdat_i / wsel_i / wdat_valid_i  in  32/4/1  write data stream.
- wdat_ready_o  out  1  write word consumed (= wb_ack_i & wb_stb_o & wb_we_o).
- rdat_o  out  32  registered read data; rdat_valid_o  out  1  one-cycle strobe, no backpressure.
- done_o  out  1  one-cycle pulse after the final ack of a command.
- wb_adr_o 32, wb_dat_o 32, wb_sel_o 4, wb_we_o 1, wb_cyc_o 1, wb_stb_o 1, wb_cti_o 3, wb_bte_o 2  out  Wishbone initiator outputs.
- wb_dat_i  in  32, wb_ack_i  in  1  Wishbone responses.

## Operation
- States: IDLE, READ, WRITE.
- IDLE: cmd_ready_o=1; on accept latch adr (with [1:0]=0), bte, beats_left=cmd_len_i, go READ or WRITE; wb_cyc_o, wb_we_o, wb_adr_o, wb_bte_o, wb_cti_o become valid at that edge.
- wb_cti_o: 000 when cmd_len_i=0 (classic); otherwise 010 while beats_left≠0, 111 when beats_left=0 (last beat).
- READ: wb_stb_o=wb_cyc_o=1, wb_sel_o=4'hf. Each ack: rdat_o<=wb_dat_i, rdat_valid_o<=1, address advances, beats_left decrements.
- WRITE: wb_cyc_o=1; wb_stb_o = wdat_valid_i (combinational wait state when no data; cti/adr held). wb_dat_o=wdat_i, wb_sel_o=wsel_i passthrough. Ack with stb high consumes the word.
- Address advance on ack: linear adr+4 (32-bit wrap at 2^32); wrap4 advances [3:0] mod 16; wrap8 [4:0] mod 32; wrap16 [5:0] mod 64; upper bits unchanged.
- Last ack (beats_left=0): cyc/stb/we drop at that edge, state IDLE, done_o=1 for exactly the next cycle; a new command may be accepted in that same cycle.
- wb_ack_i while wb_stb_o=0 is ignored (no count, no data).

## Timing
- Reset (async assert, sync-released internally): wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_dat_o follows wdat_i, wb_sel_o=0, wb_cti_o=000, wb_bte_o=00, rdat_o=0, rdat_valid_o=0, done_o=0, cmd_ready_o=1, state IDLE.
- Reset asserted mid-burst: bus outputs drop immediately (asynchronously); no done_o; burst abandoned.
- Command accept at edge N -> wb_cyc_o/wb_stb_o (read) high from N.
- Read data: ack sampled at edge M -> rdat_valid_o high and rdat_o valid during cycle after M.
- Zero-wait slave: L+1 beats complete in L+1 cycles; done_o in cycle L+2 after accept.
- Back-to-back commands: minimum one cycle with cyc low between commands (the done_o/IDLE cycle).
- cmd_valid_i while busy: ignored, cmd_ready_o=0.

## Test plan
- Single read: cmd adr=0x100, len=0 -> one beat cti=000, sel=f, adr 0x100; slave returns 0xDEADBEEF -> rdat_valid_o pulse with 0xDEADBEEF, done_o one cycle later.
- Wrap4 read: adr=0x1008, len=3, bte=01 -> addresses 0x1008,0x100C,0x1000,0x1004; cti 010,010,010,111; four rdat_valid_o pulses.
- Linear write len=7 from adr 0xFFFFFFF8 with wdat_valid_i low on beat 3 for 2 cycles -> stb drops 2 cycles, adr/cti held; addresses wrap 0xFFFFFFF8,0xFFFFFFFC,0x0,...; 8 wdat_ready_o pulses, sel passed through.
- Slave wait states: ack every 3rd cycle on wrap16 len=15 from 0x2034 -> 16 beats, addresses mod 64 within 0x2000–0x203C, done_o once.
- Stray ack while stb low (write stalled) -> no beat counted, no wdat_ready_o.
- wb_rst_n pulled low at beat 2 of an 8-beat read -> cyc/stb low same cycle, no done_o; after release cmd_ready_o=1 and a new command completes normally.
